// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - gate model stimulus/capture sequencer with MISR signature (optional macro GATE_SEQ_SIGCHK_EN)
module gate_test_sequencer #(
   parameter int VEC_W  = 10,
   parameter int RSP_W  = 10,
   parameter int SIG_W  = 16,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic             abort,
   output logic [VEC_W-1:0] stim,
   input  logic [RSP_W-1:0] rsp,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] pat_count
`ifdef GATE_SEQ_SIGCHK_EN
   ,
   input  logic [SIG_W-1:0] exp_sig,
   output logic             pass
`endif
);

   localparam int SETW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SIG_W-1:0] POLY    = SIG_W'(16'h1021);
   localparam logic [SIG_W-1:0] SIG_INI = '1;
   localparam logic [SETW-1:0]  SET_LAST = SETW'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_mode;
   logic [CNT_W-1:0] r_num;
   logic [SETW-1:0]  r_settle;
   logic [VEC_W-1:0] r_stim;
   logic [SIG_W-1:0] r_sig;
   logic [CNT_W-1:0] r_pat;
   logic             r_busy;
   logic             r_done;

   logic             w_start;
   logic             w_capture;
   logic             w_abort;
   logic [CNT_W-1:0] w_pat_inc;
   logic [VEC_W-1:0] w_stim_adv;
   logic [SIG_W-1:0] w_rsp_ext;
   logic [SIG_W-1:0] w_sig_cap;

   assign stim      = r_stim;
   assign signature = r_sig;
   assign pat_count = r_pat;
   assign busy      = r_busy;
   assign done      = r_done;
   assign w_pat_inc = r_pat + 1'b1;

   // Next stimulus vector and next MISR value for a capture edge
   always_comb begin
      w_rsp_ext = '0;
      w_rsp_ext[RSP_W-1:0] = rsp;
      if (r_mode) begin
         w_stim_adv = {r_stim[VEC_W-2:0], r_stim[VEC_W-1] ^ r_stim[6]};
      end else begin
         w_stim_adv = r_stim + 1'b1;
      end
      w_sig_cap = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ w_rsp_ext;
   end

   // Next-state decode plus the start/capture/abort strobes used by the datapath
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_capture   = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start     = 1'b1;
               w_state_nxt = (num_patterns == '0) ? S_DONE : S_APPLY;
            end
         end
         S_APPLY: begin
            if (abort) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_settle == SET_LAST) begin
               w_capture = 1'b1;
               if (w_pat_inc == r_num) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register with busy/done registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_APPLY);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   // Run configuration latched when a run is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= 1'b0;
         r_num  <= '0;
      end else if (w_start) begin
         r_mode <= mode;
         r_num  <= num_patterns;
      end
   end

   // Settle counter: counts cycles the current vector has been held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_settle <= '0;
      end else if (w_start || w_capture) begin
         r_settle <= '0;
      end else if (r_state == S_APPLY && !abort) begin
         r_settle <= r_settle + 1'b1;
      end
   end

   // Stimulus, signature and pattern count; abort leaves partial results in place
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stim <= '0;
         r_sig  <= SIG_INI;
         r_pat  <= '0;
      end else if (w_start) begin
         r_stim <= mode ? VEC_W'(1) : '0;
         r_sig  <= SIG_INI;
         r_pat  <= '0;
      end else if (w_capture) begin
         r_stim <= w_stim_adv;
         r_sig  <= w_sig_cap;
         r_pat  <= w_pat_inc;
      end
   end

`ifdef GATE_SEQ_SIGCHK_EN
   logic [SIG_W-1:0] r_exp_sig;
   logic             r_pass;
   logic [SIG_W-1:0] w_sig_entry;
   logic [SIG_W-1:0] w_exp_cur;
   logic             w_done_entry;

   assign pass = r_pass;

   // Signature value and expectation in force on the edge that enters DONE
   always_comb begin
      w_sig_entry  = w_start ? SIG_INI : w_sig_cap;
      w_exp_cur    = (r_state == S_IDLE) ? exp_sig : r_exp_sig;
      w_done_entry = (w_state_nxt == S_DONE) && (r_state != S_DONE);
   end

   // Expected signature latched with the run configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp_sig <= '0;
      end else if (w_start) begin
         r_exp_sig <= exp_sig;
      end
   end

   // Pass flag: judged on DONE entry, cleared when a run starts or is aborted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pass <= 1'b0;
      end else if (w_done_entry) begin
         r_pass <= (w_sig_entry == w_exp_cur);
      end else if (w_start || w_abort) begin
         r_pass <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - self-checking bench for gate_test_sequencer
module tb_gate_test_sequencer;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [10:0] num_patterns;
   logic        abort;
   logic [9:0]  stim;
   logic [9:0]  rsp;
   logic        busy;
   logic        done;
   logic [15:0] signature;
   logic [10:0] pat_count;
   logic [15:0] exp_sig;
   logic        pass;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   logic [9:0] g_key = 10'h000;
   bit         g_zero = 1'b1;

   gate_test_sequencer #(
      .VEC_W(10), .RSP_W(10), .SIG_W(16), .SETTLE(SETTLE), .CNT_W(11)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .mode(mode),
      .num_patterns(num_patterns),
      .abort(abort),
      .stim(stim),
      .rsp(rsp),
      .busy(busy),
      .done(done),
      .signature(signature),
      .pat_count(pat_count)
`ifdef GATE_SEQ_SIGCHK_EN
      ,
      .exp_sig(exp_sig),
      .pass(pass)
`endif
   );

`ifndef GATE_SEQ_SIGCHK_EN
   assign pass = 1'b0;
`endif

   always #5 clk = ~clk;

   // stand-in combinational gate model
   always_comb rsp = g_zero ? 10'h000 : ((stim ^ g_key) + {stim[4:0], stim[9:5]});

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
      end
   endtask

   // behavioural reference model
   bit          m_run = 0;
   bit          m_done = 0;
   bit          m_mode = 0;
   int          m_num = 0;
   int          m_el = 0;
   int          m_cnt = 0;
   logic [9:0]  m_stim = '0;
   logic [15:0] m_sig = 16'hFFFF;
   logic [15:0] m_exp = '0;
   bit          m_pass = 0;
   logic [9:0]  m_r;
   logic [9:0]  lfsr_log[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_done = 0; m_stim = '0; m_sig = 16'hFFFF; m_cnt = 0; m_el = 0; m_pass = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_run) begin
         if (start) begin
            m_mode = mode; m_num = int'(num_patterns); m_exp = exp_sig;
            m_stim = mode ? 10'h001 : 10'h000;
            m_sig = 16'hFFFF; m_cnt = 0; m_el = 0; m_pass = 0;
            if (m_num == 0) begin
               m_done = 1; m_pass = (m_sig == m_exp);
            end else begin
               m_run = 1;
            end
         end
      end else if (abort) begin
         m_run = 0; m_pass = 0;
      end else begin
         m_el++;
         if (m_el % SETTLE == 0) begin
            if (m_mode) lfsr_log.push_back(m_stim);
            m_r = g_zero ? 10'h000 : ((m_stim ^ g_key) + {m_stim[4:0], m_stim[9:5]});
            m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ {6'b0, m_r};
            m_cnt++;
            m_stim = m_mode ? {m_stim[8:0], m_stim[9] ^ m_stim[6]} : m_stim + 10'd1;
            if (m_cnt == m_num) begin
               m_run = 0; m_done = 1; m_pass = (m_sig == m_exp);
            end
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         chk("cyc_stim", stim, m_stim);
         chk("cyc_busy", busy, m_run);
         chk("cyc_done", done, m_done);
         chk("cyc_sig", signature, m_sig);
         chk("cyc_pat", pat_count, m_cnt);
`ifdef GATE_SEQ_SIGCHK_EN
         chk("cyc_pass", pass, m_pass);
`endif
      end
   end

   task automatic pulse_start(input bit md, input logic [10:0] n, input logic [15:0] es);
      start = 1'b1; mode = md; num_patterns = n; exp_sig = es;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_stim"}, stim, 10'h000);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_sig"}, signature, 16'hFFFF);
      chk({tag, "_pat"}, pat_count, 11'd0);
`ifdef GATE_SEQ_SIGCHK_EN
      chk({tag, "_pass"}, pass, 1'b0);
`endif
   endtask

   initial begin
      logic [9:0] exp_lfsr[8];
      int cyc;
      exp_lfsr = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h081};
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; num_patterns = '0; abort = 1'b0; exp_sig = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      // single pattern, zero response
      pulse_start(1'b0, 11'd1, 16'hEFDF);
      chk("s1_stim", stim, 10'h000);
      chk("s1_busy", busy, 1'b1);
      wait_done(cyc);
      chk("s1_done_cyc", cyc, 3);
      chk("s1_busy_at_done", busy, 1'b0);
      chk("s1_sig", signature, 16'hEFDF);
      chk("s1_pat", pat_count, 11'd1);
`ifdef GATE_SEQ_SIGCHK_EN
      chk("s1_pass", pass, 1'b1);
`endif
      @(negedge clk);
      pulse_start(1'b0, 11'd1, 16'h0000);
      wait_done(cyc);
      chk("s1b_sig", signature, 16'hEFDF);
`ifdef GATE_SEQ_SIGCHK_EN
      chk("s1b_pass", pass, 1'b0);
`endif
      @(negedge clk);

      // four counter patterns
      pulse_start(1'b0, 11'd4, 16'h0000);
      wait_done(cyc);
      chk("s2_done_cyc", cyc, 9);
      @(negedge clk);
      chk("s2_stim_after", stim, 10'h004);
      chk("s2_pat", pat_count, 11'd4);

      // eight LFSR patterns
      lfsr_log.delete();
      pulse_start(1'b1, 11'd8, 16'h0000);
      wait_done(cyc);
      chk("s3_done_cyc", cyc, 17);
      chk("s3_len", lfsr_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < lfsr_log.size()) chk("s3_lfsr_seq", lfsr_log[i], exp_lfsr[i]);
      end
      chk("s3_stim_after", stim, 10'h102);
      @(negedge clk);

      // zero patterns
      pulse_start(1'b0, 11'd0, 16'hFFFF);
      chk("s4_done", done, 1'b1);
      chk("s4_busy", busy, 1'b0);
      chk("s4_sig", signature, 16'hFFFF);
      chk("s4_pat", pat_count, 11'd0);
`ifdef GATE_SEQ_SIGCHK_EN
      chk("s4_pass", pass, 1'b1);
`endif
      @(negedge clk);

      // abort sampled at E0+5, then immediate restart
      g_zero = 1'b0; g_key = 10'h2A5;
      pulse_start(1'b0, 11'd10, 16'h0000);
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("s5_busy", busy, 1'b0);
      chk("s5_done", done, 1'b0);
      chk("s5_pat", pat_count, 11'd2);
      pulse_start(1'b0, 11'd3, 16'h0000);
      chk("s5_restart_sig", signature, 16'hFFFF);
      chk("s5_restart_pat", pat_count, 11'd0);
      chk("s5_restart_busy", busy, 1'b1);
      wait_done(cyc);
      chk("s5_restart_done_cyc", cyc, 7);
      @(negedge clk);

      // asynchronous reset mid-run
      pulse_start(1'b1, 11'd10, 16'h0000);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("arst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         start = ($urandom_range(0, 5) == 0);
         abort = ($urandom_range(0, 19) == 0);
         mode = 1'($urandom_range(0, 1));
         num_patterns = 11'($urandom_range(0, 12));
         exp_sig = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
         if (c % 100 == 0) begin
            g_key = 10'($urandom);
            g_zero = ($urandom_range(0, 3) == 0);
         end
         @(negedge clk);
      end
      start = 1'b0; abort = 1'b0;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
